// File: rtl/grid_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_io_pkg
// Description : Shared constants, safe pad state and config FSM encoding for
//               the I/O grid tile.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_io_pkg;

    localparam int CFG_BITS_PER_IO = 2;
    localparam int DIR_BIT         = 0;
    localparam int INV_BIT         = 1;

    // Pad state forced while isolated or never configured: input direction, no drive
    localparam logic C_SAFE_DIR   = 1'b1;
    localparam logic C_SAFE_OUT   = 1'b0;
    localparam logic C_SAFE_INPAD = 1'b0;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } cfg_state_e;

    function automatic cfg_state_e state_of(input int cnt, input int total);
        if (cnt == 0)
            state_of = EMPTY;
        else if (cnt >= total)
            state_of = FULL;
        else
            state_of = LOADING;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_io_cfg_chan.sv
`default_nettype none
// ============================================================================
// Module      : grid_io_cfg_chan
// Description : Per-pad datapath; applies committed direction/polarity or the
//               safe state when the tile is inactive.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_io_cfg_chan
    import grid_io_pkg::*;
(
    input  logic i_dir,
    input  logic i_inv,
    input  logic i_active,
    input  logic i_soc_in,
    input  logic i_outpad,
    output logic o_soc_dir,
    output logic o_soc_out,
    output logic o_inpad
);

    always_comb begin
        o_soc_dir = C_SAFE_DIR;
        o_soc_out = C_SAFE_OUT;
        o_inpad   = C_SAFE_INPAD;
        if (i_active) begin
            o_soc_dir = i_dir;
            o_soc_out = i_dir ? 1'b0 : (i_outpad ^ i_inv);
            o_inpad   = i_dir ? (i_soc_in ^ i_inv) : 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/grid_io_cfg_tile.sv
`default_nettype none
// ============================================================================
// Module      : grid_io_cfg_tile
// Description : I/O grid tile with ccff scan segment, guarded commit to a
//               shadow configuration and per-pad direction/polarity control.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_io_cfg_tile
    import grid_io_pkg::*;
#(
    parameter int NUM_IO = 4
)
(
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              isol_n,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              cfg_commit,
    output logic              ccff_tail,
    output logic              cfg_valid,
    output logic              cfg_commit_ack,
    output logic              cfg_err,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    input  logic [NUM_IO-1:0] outpad,
    output logic [NUM_IO-1:0] inpad
);

    localparam int TOTAL_BITS = NUM_IO * CFG_BITS_PER_IO;
    localparam int CW         = $clog2(TOTAL_BITS + 1);

    logic [TOTAL_BITS-1:0] r_sr;
    logic [TOTAL_BITS-1:0] r_shadow;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    cfg_state_e            r_state;
    logic                  r_valid;
    logic                  r_ack;
    logic                  r_err;
    logic                  w_active;

    // A commit always restarts the count; a shift in the same cycle counts as the first bit
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (cfg_commit)
            w_cnt_nxt = ccff_en ? CW'(1) : '0;
        else if (ccff_en && r_state != FULL)
            w_cnt_nxt = r_cnt + CW'(1);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_sr     <= '0;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_state  <= EMPTY;
            r_valid  <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= state_of(int'(w_cnt_nxt), TOTAL_BITS);
            r_ack   <= 1'b0;
            if (ccff_en)
                r_sr <= {r_sr[TOTAL_BITS-2:0], ccff_head};
            if (cfg_commit) begin
                if (r_state == FULL) begin
                    r_shadow <= r_sr;
                    r_valid  <= 1'b1;
                    r_ack    <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign ccff_tail      = r_sr[TOTAL_BITS-1];
    assign cfg_valid      = r_valid;
    assign cfg_commit_ack = r_ack;
    assign cfg_err        = r_err;
    assign w_active       = isol_n & r_valid;

    for (genvar i = 0; i < NUM_IO; i++) begin : g_chan
        grid_io_cfg_chan u_chan (
            .i_dir     (r_shadow[CFG_BITS_PER_IO*i + DIR_BIT]),
            .i_inv     (r_shadow[CFG_BITS_PER_IO*i + INV_BIT]),
            .i_active  (w_active),
            .i_soc_in  (gfpga_pad_io_soc_in[i]),
            .i_outpad  (outpad[i]),
            .o_soc_dir (gfpga_pad_io_soc_dir[i]),
            .o_soc_out (gfpga_pad_io_soc_out[i]),
            .o_inpad   (inpad[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_io_cfg_tile.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_io_cfg_tile
// Description : Directed self-checking bench for grid_io_cfg_tile (NUM_IO = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_io_cfg_tile;

    localparam int NUM_IO = 4;

    logic              prog_clk;
    logic              prog_reset;
    logic              isol_n;
    logic              ccff_head;
    logic              ccff_en;
    logic              cfg_commit;
    logic              ccff_tail;
    logic              cfg_valid;
    logic              cfg_commit_ack;
    logic              cfg_err;
    logic [NUM_IO-1:0] soc_in;
    logic [NUM_IO-1:0] soc_out;
    logic [NUM_IO-1:0] soc_dir;
    logic [NUM_IO-1:0] outpad;
    logic [NUM_IO-1:0] inpad;

    int n_checks = 0;
    int n_errors = 0;

    grid_io_cfg_tile #(.NUM_IO(NUM_IO)) dut (
        .prog_clk             (prog_clk),
        .prog_reset           (prog_reset),
        .isol_n               (isol_n),
        .ccff_head            (ccff_head),
        .ccff_en              (ccff_en),
        .cfg_commit           (cfg_commit),
        .ccff_tail            (ccff_tail),
        .cfg_valid            (cfg_valid),
        .cfg_commit_ack       (cfg_commit_ack),
        .cfg_err              (cfg_err),
        .gfpga_pad_io_soc_in  (soc_in),
        .gfpga_pad_io_soc_out (soc_out),
        .gfpga_pad_io_soc_dir (soc_dir),
        .outpad               (outpad),
        .inpad                (inpad)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bits(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            ccff_en   = 1'b1;
            ccff_head = bits[k];
            step();
        end
        ccff_en = 1'b0;
    endtask

    task automatic commit(input logic with_shift, input logic head);
        cfg_commit = 1'b1;
        ccff_en    = with_shift;
        ccff_head  = head;
        step();
        cfg_commit = 1'b0;
        ccff_en    = 1'b0;
    endtask

    task automatic check_pads(input string tag, input logic [3:0] dir, input logic [3:0] sout,
                              input logic [3:0] inp);
        check({tag, "_dir"}, 32'(soc_dir), 32'(dir));
        check({tag, "_out"}, 32'(soc_out), 32'(sout));
        check({tag, "_inpad"}, 32'(inpad), 32'(inp));
    endtask

    initial begin
        logic [11:0] tail_exp;
        prog_reset = 1'b1;
        isol_n     = 1'b1;
        ccff_head  = 1'b0;
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
        soc_in     = 4'b1111;
        outpad     = 4'b1111;
        step();
        step();
        prog_reset = 1'b0;

        // Reset state: pads safe, nothing valid
        check_pads("rst", 4'b1111, 4'b0000, 4'b0000);
        check("rst_valid", 32'(cfg_valid), 32'd0);
        check("rst_tail", 32'(ccff_tail), 32'd0);
        check("rst_ack", 32'(cfg_commit_ack), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);

        // Bits 0,1,0,0,1,1,0,1 (first first): sr = 8'b0100_1101
        shift_bits(16'b0100_1101, 8);
        check("pre_commit_valid", 32'(cfg_valid), 32'd0);
        check_pads("pre_commit", 4'b1111, 4'b0000, 4'b0000);
        commit(1'b0, 1'b0);
        check("c1_ack", 32'(cfg_commit_ack), 32'd1);
        check("c1_valid", 32'(cfg_valid), 32'd1);
        check_pads("c1_ones", 4'b1011, 4'b0100, 4'b1001);
        step();
        check("c1_ack_drop", 32'(cfg_commit_ack), 32'd0);
        soc_in = 4'b0000;
        outpad = 4'b0000;
        #1;
        check_pads("c1_zeros", 4'b1011, 4'b0000, 4'b0010);

        // Incomplete segment: error, shadow untouched; sr becomes 8'b1011_1111
        shift_bits(16'b1_1111, 5);
        commit(1'b0, 1'b0);
        check("c2_ack", 32'(cfg_commit_ack), 32'd0);
        check("c2_err", 32'(cfg_err), 32'd1);
        check("c2_valid", 32'(cfg_valid), 32'd1);
        check_pads("c2", 4'b1011, 4'b0000, 4'b0010);

        // 12-bit pass-through: old sr bits first, then the input delayed by 8
        tail_exp = 12'b0111_1110_1101;
        for (int k = 0; k < 12; k++) begin
            logic [11:0] seq;
            seq       = 12'b0110_1000_1101;
            ccff_en   = 1'b1;
            ccff_head = seq[11-k];
            step();
            check($sformatf("tail_%0d", k), 32'(ccff_tail), 32'(tail_exp[11-k]));
        end
        ccff_en = 1'b0;
        soc_in  = 4'b1111;
        outpad  = 4'b1111;
        commit(1'b0, 1'b0);
        check("c3_ack", 32'(cfg_commit_ack), 32'd1);
        check("c3_err_sticky", 32'(cfg_err), 32'd1);
        check_pads("c3", 4'b0011, 4'b0100, 4'b0001);

        // Commit with a simultaneous shift captures the pre-shift sr
        shift_bits(16'b1111_0000, 8);
        commit(1'b1, 1'b1);
        check("c4_ack", 32'(cfg_commit_ack), 32'd1);
        check_pads("c4", 4'b1100, 4'b0011, 4'b0000);

        // Count restarted at 1, so 7 more shifts complete the segment
        shift_bits(16'b010_1010, 7);
        outpad = 4'b0101;
        commit(1'b0, 1'b0);
        check("c5_ack", 32'(cfg_commit_ack), 32'd1);
        check_pads("c5", 4'b0000, 4'b1010, 4'b0000);

        // Only 1 + 6 bits: commit must be refused
        commit(1'b1, 1'b0);
        check("c6_ack", 32'(cfg_commit_ack), 32'd0);
        shift_bits(16'b11_1111, 6);
        commit(1'b0, 1'b0);
        check("c7_ack", 32'(cfg_commit_ack), 32'd0);
        check_pads("c7", 4'b0000, 4'b1010, 4'b0000);

        // Isolation forces safe state combinationally and releases cleanly
        isol_n = 1'b0;
        #1;
        check_pads("isol", 4'b1111, 4'b0000, 4'b0000);
        isol_n = 1'b1;
        #1;
        check_pads("unisol", 4'b0000, 4'b1010, 4'b0000);

        // Reset mid-load clears everything
        shift_bits(16'b101, 3);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        check("midrst_valid", 32'(cfg_valid), 32'd0);
        check("midrst_err", 32'(cfg_err), 32'd0);
        check("midrst_tail", 32'(ccff_tail), 32'd0);
        check_pads("midrst", 4'b1111, 4'b0000, 4'b0000);

        // Commit on a reset cycle is ignored and the count is cleared
        shift_bits(16'b1111_1111, 8);
        prog_reset = 1'b1;
        commit(1'b0, 1'b0);
        prog_reset = 1'b0;
        check("rstcommit_ack", 32'(cfg_commit_ack), 32'd0);
        check("rstcommit_valid", 32'(cfg_valid), 32'd0);
        commit(1'b0, 1'b0);
        check("post_rst_err", 32'(cfg_err), 32'd1);
        check("post_rst_ack", 32'(cfg_commit_ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
